// File: rtl/seg_mod_pkg.sv
// rtl/seg_mod_pkg.sv - shared constants and state type for the BPSK segment mapper
package seg_mod_pkg;

    localparam logic [31:0] Q16_POS   = 32'h0001_0000;
    localparam logic [31:0] Q16_NEG   = 32'hFFFF_0000;
    localparam int          SEG_W     = 4;
    localparam logic [6:0]  LFSR_SEED = 7'h7F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2
    } state_t;

endpackage

// File: rtl/seg_bpsk_lfsr.sv
// rtl/seg_bpsk_lfsr.sv - x^7+x^4+1 keystream generator with reload and step controls
module seg_bpsk_lfsr
    import seg_mod_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic reload,
    input  logic step,
    output logic ks
);

    logic [6:0] lfsr_q;

    assign ks = lfsr_q[6] ^ lfsr_q[3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else if (reload) begin
            lfsr_q <= LFSR_SEED;
        end else if (step) begin
            lfsr_q <= {lfsr_q[5:0], ks};
        end
    end

endmodule

// File: rtl/seg_bpsk_frame_sched.sv
// rtl/seg_bpsk_frame_sched.sv - collects NUM_SEG bits per frame and emits mapped Q16.16 BPSK symbols
// Optional bit scrambling is enabled by defining SEG_BPSK_SCRAMBLE_EN.
module seg_bpsk_frame_sched
    import seg_mod_pkg::*;
#(
    parameter int                 NUM_SEG  = 10,
    parameter int                 DATA_W   = 32,
    parameter logic [DATA_W-1:0]  POS_VAL  = Q16_POS,
    parameter logic [DATA_W-1:0]  NEG_VAL  = Q16_NEG,
    parameter logic [NUM_SEG-1:0] POL_MASK = 10'b00_0010_0110
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_bit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SEG_W-1:0]  out_seg,
    output logic              out_last,
    output logic [15:0]       frame_cnt
);

    localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'(NUM_SEG - 1);

    state_t              state_q, state_d;
    logic [NUM_SEG-1:0]  bits_q, bits_d;
    logic [SEG_W-1:0]    cnt_q, cnt_d;
    logic [SEG_W-1:0]    seg_nxt;
    logic                busy_d, done_d, in_ready_d;
    logic                out_valid_d, out_last_d;
    logic [DATA_W-1:0]   out_data_d;
    logic [SEG_W-1:0]    out_seg_d;
    logic [15:0]         frame_cnt_d;
    logic                ks;

    function automatic logic [DATA_W-1:0] map_sym(input logic [NUM_SEG-1:0] bits,
                                                  input logic [SEG_W-1:0]   idx);
        return (bits[idx] ^ POL_MASK[idx]) ? POS_VAL : NEG_VAL;
    endfunction

`ifdef SEG_BPSK_SCRAMBLE_EN
    logic lfsr_reload;
    logic lfsr_step;

    // Reseeding on every accepted start makes each frame's keystream identical.
    assign lfsr_reload = (state_q == IDLE) && start && !done;
    assign lfsr_step   = (state_q == LOAD) && in_valid && in_ready;

    seg_bpsk_lfsr u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .reload (lfsr_reload),
        .step   (lfsr_step),
        .ks     (ks)
    );
`else
    assign ks = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bits_q    <= '0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_seg   <= '0;
            out_last  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state_q   <= state_d;
            bits_q    <= bits_d;
            cnt_q     <= cnt_d;
            busy      <= busy_d;
            done      <= done_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_seg   <= out_seg_d;
            out_last  <= out_last_d;
            frame_cnt <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bits_d      = bits_q;
        cnt_d       = cnt_q;
        busy_d      = busy;
        done_d      = 1'b0;
        in_ready_d  = in_ready;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_seg_d   = out_seg;
        out_last_d  = out_last;
        frame_cnt_d = frame_cnt;
        seg_nxt     = out_seg + SEG_W'(1);

        unique case (state_q)
            IDLE: begin
                // The done cycle itself does not accept start, giving the 2-cycle frame gap.
                if (start && !done) begin
                    state_d    = LOAD;
                    busy_d     = 1'b1;
                    in_ready_d = 1'b1;
                    cnt_d      = '0;
                end
            end
            LOAD: begin
                if (in_valid && in_ready) begin
                    bits_d[cnt_q] = in_bit ^ ks;
                    cnt_d         = cnt_q + SEG_W'(1);
                    if (cnt_q == LAST_SEG) begin
                        state_d     = EMIT;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                        out_seg_d   = '0;
                        out_last_d  = 1'b0;
                        out_data_d  = map_sym(bits_d, '0);
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (out_last) begin
                        state_d     = IDLE;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_seg_d   = '0;
                        out_data_d  = '0;
                        frame_cnt_d = frame_cnt + 16'd1;
                    end else begin
                        out_seg_d  = seg_nxt;
                        out_data_d = map_sym(bits_q, seg_nxt);
                        out_last_d = (seg_nxt == LAST_SEG);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seg_bpsk_frame_sched.sv
// tb/tb_seg_bpsk_frame_sched.sv - scoreboard bench for seg_bpsk_frame_sched
`timescale 1ns/1ps
module tb_seg_bpsk_frame_sched;

    localparam logic [9:0]  POL = 10'b00_0010_0110;
    localparam logic [31:0] POS = 32'h0001_0000;
    localparam logic [31:0] NEG = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_bit = 1'b0;
    logic        out_ready = 1'b0;
    logic        busy, done, in_ready, out_valid, out_last;
    logic [31:0] out_data;
    logic [3:0]  out_seg;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    seg_bpsk_frame_sched dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_seg   (out_seg),
        .out_last  (out_last),
        .frame_cnt (frame_cnt)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  seg;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   exp_frames = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic ks_bit(input int idx);
        logic [6:0] l = 7'h7F;
        logic       s = 1'b0;
        for (int k = 0; k <= idx; k++) begin
            s = l[6] ^ l[3];
            l = {l[5:0], s};
        end
        return s;
    endfunction

    function automatic logic [31:0] exp_sym(input logic [0:9] bits, input int idx);
        logic b;
        b = bits[idx];
`ifdef SEG_BPSK_SCRAMBLE_EN
        b = b ^ ks_bit(idx);
`endif
        return (b ^ POL[idx]) ? POS : NEG;
    endfunction

    task automatic push_frame(input logic [0:9] bits, input int n);
        for (int idx = 0; idx < n; idx++)
            sb.push_back('{data: exp_sym(bits, idx), seg: 4'(idx), last: (idx == 9)});
    endtask

    task automatic do_start;
        int cyc = 0;
        @(negedge clk);
        start = 1'b1;
        while (!busy && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk(busy, "start_busy", 32'(busy), 32'd1);
        chk(in_ready, "load_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic feed(input logic [0:9] bits, input bit stall, input bit pulse);
        int  i = 0;
        int  cyc = 0;
        bit  odd = 1'b0;
        while (i < 10 && cyc < 100) begin
            @(negedge clk);
            start    = pulse && (i == 5);
            in_valid = !(stall && odd);
            in_bit   = bits[i];
            odd      = !odd;
            if (in_valid && in_ready) begin
                if (i == 9) chk(!out_valid, "no_early_valid", 32'(out_valid), 32'd0);
                i++;
            end
            cyc++;
        end
        if (i < 10) chk(1'b0, "feed_timeout", 32'(i), 32'd10);
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        chk(out_valid, "first_valid_latency", 32'(out_valid), 32'd1);
        chk(!in_ready, "in_ready_drop", 32'(in_ready), 32'd0);
    endtask

    task automatic drain(input bit bp, input bit pulse);
        int  hold = 0;
        int  cyc = 0;
        bit  seen = 1'b0;
        while (!seen && cyc < 200) begin
            start = pulse && (cyc == 2);
            if (bp && out_valid && out_seg == 4'd3 && hold < 5) begin
                out_ready = 1'b0;
                hold++;
            end else begin
                out_ready = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
        end
        start     = 1'b0;
        out_ready = 1'b0;
        if (!seen) chk(1'b0, "drain_timeout", 32'(cyc), 32'd200);
    endtask

    task automatic run_frame(input logic [0:9] bits, input bit stall, input bit bp, input bit pulse);
        do_start();
        push_frame(bits, 10);
        feed(bits, stall, pulse);
        drain(bp, pulse);
        repeat (4) @(negedge clk);
        #2;
        chk(!busy && !in_ready && !out_valid, "idle_after_frame",
            {29'd0, busy, in_ready, out_valid}, 32'd0);
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks holds/done.
    initial begin
        exp_t        e;
        bit          prev_stall = 1'b0;
        bit          prev_last_hs = 1'b0;
        bit          busy_prev = 1'b0;
        logic [31:0] prev_data = '0;
        logic [3:0]  prev_seg = '0;
        bit          hs;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                prev_stall   = 1'b0;
                prev_last_hs = 1'b0;
                busy_prev    = 1'b0;
                continue;
            end
            if (prev_stall)
                chk(out_valid && out_data == prev_data && out_seg == prev_seg, "stall_hold",
                    {out_data[31:4], out_seg}, {prev_data[31:4], prev_seg});
            if (prev_last_hs || done) begin
                chk(done == prev_last_hs, "done_pulse", 32'(done), 32'(prev_last_hs));
                if (prev_last_hs) begin
                    chk(!busy && !out_valid, "busy_clear", {30'd0, busy, out_valid}, 32'd0);
                    chk(frame_cnt == 16'(exp_frames), "frame_cnt", 32'(frame_cnt), 32'(exp_frames));
                end
            end
            if (busy_prev && !busy)
                chk(prev_last_hs, "busy_early_drop", 32'(busy), 32'd1);
            hs           = out_valid && out_ready;
            prev_last_hs = 1'b0;
            if (hs) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_symbol", {28'd0, out_seg}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk(out_data == e.data, "sym_data", out_data, e.data);
                    chk(out_seg == e.seg, "sym_seg", 32'(out_seg), 32'(e.seg));
                    chk(out_last == e.last, "sym_last", 32'(out_last), 32'(e.last));
                    if (e.last) begin
                        prev_last_hs = 1'b1;
                        exp_frames++;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_seg   = out_seg;
            busy_prev  = busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk({busy, done, in_ready, out_valid, out_last} == 5'd0, "reset_flags",
            {27'd0, busy, done, in_ready, out_valid, out_last}, 32'd0);
        chk(out_data == 32'd0 && out_seg == 4'd0, "reset_data", out_data | 32'(out_seg), 32'd0);
        chk(frame_cnt == 16'd0, "reset_frame_cnt", 32'(frame_cnt), 32'd0);
        reset = 1'b0;

        // Reset while emitting segment 4 discards the frame.
        do_start();
        push_frame(10'b0110100111, 4);
        feed(10'b0110100111, 1'b0, 1'b0);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        #2;
        chk(out_valid && out_seg == 4'd4, "pre_reset_seg", 32'(out_seg), 32'd4);
        chk(sb.size() == 0, "pre_reset_consumed", 32'(sb.size()), 32'd0);
        reset = 1'b1;
        #1;
        chk({busy, done, in_ready, out_valid, out_last} == 5'd0, "midreset_flags",
            {27'd0, busy, done, in_ready, out_valid, out_last}, 32'd0);
        chk(out_data == 32'd0 && out_seg == 4'd0, "midreset_data", out_data | 32'(out_seg), 32'd0);
        chk(frame_cnt == 16'd0, "midreset_frame_cnt", 32'(frame_cnt), 32'd0);
        @(negedge clk);
        #3;
        reset = 1'b0;
        sb.delete();

        run_frame(10'b1011001011, 1'b0, 1'b0, 1'b0);
        run_frame(10'b0100110100, 1'b0, 1'b1, 1'b0);
        run_frame(10'b1111100000, 1'b1, 1'b0, 1'b1);
        run_frame(10'b0000000000, 1'b0, 1'b0, 1'b0);
        run_frame(10'b0000000000, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        #2;
        chk(sb.size() == 0, "scoreboard_empty", 32'(sb.size()), 32'd0);
        chk(frame_cnt == 16'd5, "final_frame_cnt", 32'(frame_cnt), 32'd5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
